// File: rtl/regfile_dump_uart.sv
// regfile_dump_uart: walks registers 0..LAST_REG through a spare read port and streams them out as 8N1 UART frames
module regfile_dump_uart #(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] HEADER_BYTE  = 8'hA5,
    parameter int         LAST_REG     = 31
) (
    input  logic        clock,
    input  logic        ctrl_reset_n,
    input  logic        dump_start,
    output logic [4:0]  ctrl_readReg,
    input  logic [31:0] data_readReg,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {IDLE, TX_HDR, READ, CAPTURE, TX_WORD, DONE} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tim_q, tim_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    sh_q, sh_d;
    logic [31:0]   snap_q, snap_d;
    logic [1:0]    byte_q, byte_d;
    logic [4:0]    idx_q, idx_d;
    logic          tx_q, tx_d;
    logic          bit_end, byte_end;
    logic [1:0]    nb;
    logic [7:0]    nxt;

    always_comb begin
        state_d  = state_q;
        tim_d    = tim_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        snap_d   = snap_q;
        byte_d   = byte_q;
        idx_d    = idx_q;
        tx_d     = tx_q;
        bit_end  = tim_q == TW'(CLKS_PER_BIT - 1);
        byte_end = bit_end && bit_q == 4'd9;
        nb       = byte_q + 2'd1;
        nxt      = snap_q[{~nb, 3'b000} +: 8];
        if (state_q == TX_HDR || state_q == TX_WORD) begin
            tim_d = bit_end ? '0 : tim_q + 1'b1;
            if (bit_end && !byte_end) begin
                tx_d  = sh_q[0];
                sh_d  = {1'b0, sh_q[8:1]};
                bit_d = bit_q + 4'd1;
            end
        end
        case (state_q)
            IDLE: if (dump_start) begin
                state_d = TX_HDR;
                idx_d   = '0;
                tx_d    = 1'b0;
                sh_d    = {1'b1, HEADER_BYTE};
                bit_d   = '0;
                tim_d   = '0;
            end
            TX_HDR: if (byte_end) begin
                state_d = READ;
                tx_d    = 1'b1;
            end
            READ: state_d = CAPTURE;
            CAPTURE: begin
                state_d = TX_WORD;
                snap_d  = data_readReg;
                byte_d  = '0;
                tx_d    = 1'b0;
                sh_d    = {1'b1, data_readReg[31:24]};
                bit_d   = '0;
                tim_d   = '0;
            end
            TX_WORD: if (byte_end) begin
                if (byte_q == 2'd3) begin
                    tx_d    = 1'b1;
                    state_d = (idx_q == 5'(LAST_REG)) ? DONE : READ;
                    idx_d   = (idx_q == 5'(LAST_REG)) ? idx_q : idx_q + 5'd1;
                end else begin
                    // next byte's start bit follows the stop bit directly
                    byte_d = nb;
                    tx_d   = 1'b0;
                    sh_d   = {1'b1, nxt};
                    bit_d  = '0;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q <= IDLE;
            tim_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            snap_q  <= '0;
            byte_q  <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tim_q   <= tim_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            snap_q  <= snap_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

    assign uart_tx      = tx_q;
    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    assign ctrl_readReg = idx_q;
endmodule
